// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART serial receiver. Deserializes LSB-first frames from the
//            asynchronous rxD line into a parallel byte. It raises rdrf when a
//            byte is ready, and reports framing (fe) and overrun (oe) errors.
//            rdrf, fe and oe stay set until the consumer acknowledges them
//            with rdrf_clr. Bit timing matches the companion transmitter, so a
//            TX->RX loopback needs no adaptation.
// Ports    : clk      in  1  system clock, rising edge
//            clr      in  1  asynchronous active-high reset
//            rxD      in  1  serial line, idle high, asynchronous to clk
//            rdrf_clr in  1  one-cycle acknowledge, clears rdrf/fe/oe
//            rx_data  out 8  last accepted byte
//            rdrf     out 1  receive data register full
//            fe       out 1  framing error (stop bit sampled low)
//            oe       out 1  overrun (byte completed while rdrf was set)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rxD,
  input  logic       rdrf_clr,
  output logic [7:0] rx_data,
  output logic       rdrf,
  output logic       fe,
  output logic       oe
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Terminal counts: half a bit locates the start-bit centre, and a full bit
  // steps from one bit centre to the next.
  localparam logic [CW-1:0] c_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] c_BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  // Two-flop synchronizer. Both flops reset to the idle (high) level so that
  // leaving reset does not look like a start bit.
  logic sync1_q;
  logic rx_s_q;

  state_t          state_q,   state_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic [2:0]      idx_q,     idx_d;
  logic [7:0]      shift_q,   shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rdrf_q,    rdrf_d;
  logic            fe_q,      fe_d;
  logic            oe_q,      oe_d;
  logic            w_stop_sample;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rxD;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      rx_data_q <= 8'h00;
      rdrf_q    <= 1'b0;
      fe_q      <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      rdrf_q    <= rdrf_d;
      fe_q      <= fe_d;
      oe_q      <= oe_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    rdrf_d        = rdrf_q;
    fe_d          = fe_q;
    oe_d          = oe_q;
    w_stop_sample = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = 3'd0;
        if (!rx_s_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == c_HALF_LAST) begin
          cnt_d = '0;
          idx_d = 3'd0;
          // A line that is high again at mid-start was only a glitch.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == c_BIT_LAST) begin
          cnt_d = '0;
          // Shift right with the new bit in the MSB: after eight LSB-first
          // bits the first bit received ends up in bit 0.
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == c_BIT_LAST) begin
          cnt_d         = '0;
          w_stop_sample = 1'b1;
          // A low stop bit may be a break; hold off until the line idles.
          state_d = rx_s_q ? S_IDLE : S_WAIT_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Completion takes priority over an acknowledge in the same cycle: the
    // acknowledge frees the register, so the new byte is accepted cleanly.
    if (w_stop_sample) begin
      if (!rdrf_q || rdrf_clr) begin
        rx_data_d = shift_q;
        rdrf_d    = 1'b1;
        fe_d      = ~rx_s_q;
        oe_d      = 1'b0;
      end else begin
        oe_d = 1'b1;
        fe_d = fe_q | ~rx_s_q;
      end
    end else if (rdrf_clr && rdrf_q) begin
      rdrf_d = 1'b0;
      fe_d   = 1'b0;
      oe_d   = 1'b0;
    end
  end

  assign rx_data = rx_data_q;
  assign rdrf    = rdrf_q;
  assign fe      = fe_q;
  assign oe      = oe_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx. A behavioural 8N1 transmitter
//            drives rxD; expected {rx_data, fe, oe} records are queued when a
//            frame is sent and popped once the frame has been received.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       clr;
  logic       rxD;
  logic       rdrf_clr;
  logic [7:0] rx_data;
  logic       rdrf;
  logic       fe;
  logic       oe;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard entries: {data[7:0], fe, oe}.
  logic [9:0] sb_q[$];
  logic [9:0] exp_v;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk      (clk),
    .clr      (clr),
    .rxD      (rxD),
    .rdrf_clr (rdrf_clr),
    .rx_data  (rx_data),
    .rdrf     (rdrf),
    .fe       (fe),
    .oe       (oe)
  );

  always #5 clk = ~clk;

  // Behavioural transmitter: called at a falling edge, returns at one.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rxD = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxD = d[i];
      repeat (C) @(negedge clk);
    end
    rxD = stop;
    repeat (C) @(negedge clk);
  endtask

  task automatic pulse_clr();
    rdrf_clr = 1'b1;
    @(negedge clk);
    rdrf_clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] b;
    clr = 1'b1;
    rxD = 1'b1;
    rdrf_clr = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({rx_data, rdrf, fe, oe} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_values got %h required %h", {rx_data, rdrf, fe, oe}, 11'h0);
    end
    clr = 1'b0;
    repeat (4) @(negedge clk);
    // Load a byte so the mid-frame reset has something to clear.
    send_frame(8'hC3, 1'b1);
    n_tests++;
    if ({rx_data, rdrf} !== {8'hC3, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_preload got %h/%b required c3/1", rx_data, rdrf);
    end
    // Start 0x3C, then reset during data bit 3.
    b = 8'h3C;
    rxD = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rxD = b[i];
      repeat (C) @(negedge clk);
    end
    rxD = b[3];
    repeat (C / 2) @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({rx_data, rdrf, fe, oe} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_midframe got %h required %h", {rx_data, rdrf, fe, oe}, 11'h0);
    end
    rxD = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (12 * C) @(negedge clk);
    n_tests++;
    if (rdrf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort got rdrf=%b required 0", rdrf);
    end
    sb_q.push_back({8'h3C, 1'b0, 1'b0});
    send_frame(8'h3C, 1'b1);
    exp_v = sb_q.pop_front();
    n_tests++;
    if ({rx_data, fe, oe, rdrf} !== {exp_v, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_resume got %h required %h", {rx_data, fe, oe, rdrf}, {exp_v, 1'b1});
    end
    pulse_clr();
  endtask

  task automatic test_nominal();
    int lat;
    lat = 0;
    sb_q.push_back({8'hA5, 1'b0, 1'b0});
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (lat < 400) begin
          @(posedge clk);
          lat++;
          #1;
          if (rdrf === 1'b1) break;
        end
      end
    join
    n_tests++;
    if (lat < 154 || lat > 156) begin
      n_fail++;
      $display("FAIL nominal_latency got %0d required 155+-1", lat);
    end
    exp_v = sb_q.pop_front();
    n_tests++;
    if ({rx_data, fe, oe, rdrf} !== {exp_v, 1'b1}) begin
      n_fail++;
      $display("FAIL nominal_frame got %h required %h", {rx_data, fe, oe, rdrf}, {exp_v, 1'b1});
    end
    pulse_clr();
    n_tests++;
    if ({rx_data, rdrf, fe, oe} !== {8'hA5, 3'b000}) begin
      n_fail++;
      $display("FAIL nominal_ack got %h required %h", {rx_data, rdrf, fe, oe}, {8'hA5, 3'b000});
    end
    // Acknowledge with nothing pending must change nothing.
    pulse_clr();
    n_tests++;
    if ({rx_data, rdrf, fe, oe} !== {8'hA5, 3'b000}) begin
      n_fail++;
      $display("FAIL nominal_idle_ack got %h required %h", {rx_data, rdrf, fe, oe}, {8'hA5, 3'b000});
    end
  endtask

  task automatic test_glitch();
    rxD = 1'b0;
    repeat (4) @(negedge clk);
    rxD = 1'b1;
    repeat (12 * C) @(negedge clk);
    n_tests++;
    if ({rdrf, fe, oe} !== 3'b000) begin
      n_fail++;
      $display("FAIL glitch_ignored got %b required 000", {rdrf, fe, oe});
    end
    sb_q.push_back({8'h5A, 1'b0, 1'b0});
    send_frame(8'h5A, 1'b1);
    exp_v = sb_q.pop_front();
    n_tests++;
    if ({rx_data, fe, oe, rdrf} !== {exp_v, 1'b1}) begin
      n_fail++;
      $display("FAIL glitch_next got %h required %h", {rx_data, fe, oe, rdrf}, {exp_v, 1'b1});
    end
    pulse_clr();
  endtask

  task automatic test_framing();
    sb_q.push_back({8'hFF, 1'b1, 1'b0});
    send_frame(8'hFF, 1'b0);
    repeat (40) @(negedge clk);
    exp_v = sb_q.pop_front();
    n_tests++;
    if ({rx_data, fe, oe, rdrf} !== {exp_v, 1'b1}) begin
      n_fail++;
      $display("FAIL framing_err got %h required %h", {rx_data, fe, oe, rdrf}, {exp_v, 1'b1});
    end
    pulse_clr();
    // Line still held low: a retriggered frame would complete within this.
    repeat (12 * C) @(negedge clk);
    n_tests++;
    if ({rdrf, fe, oe} !== 3'b000) begin
      n_fail++;
      $display("FAIL framing_break got %b required 000", {rdrf, fe, oe});
    end
    rxD = 1'b1;
    repeat (2 * C) @(negedge clk);
    sb_q.push_back({8'h42, 1'b0, 1'b0});
    send_frame(8'h42, 1'b1);
    exp_v = sb_q.pop_front();
    n_tests++;
    if ({rx_data, fe, oe, rdrf} !== {exp_v, 1'b1}) begin
      n_fail++;
      $display("FAIL framing_recover got %h required %h", {rx_data, fe, oe, rdrf}, {exp_v, 1'b1});
    end
    pulse_clr();
  endtask

  task automatic test_back_to_back();
    // Overrun: second byte discarded, first byte kept.
    sb_q.push_back({8'h11, 1'b0, 1'b1});
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    exp_v = sb_q.pop_front();
    n_tests++;
    if ({rx_data, fe, oe, rdrf} !== {exp_v, 1'b1}) begin
      n_fail++;
      $display("FAIL overrun got %h required %h", {rx_data, fe, oe, rdrf}, {exp_v, 1'b1});
    end
    pulse_clr();
    n_tests++;
    if ({rdrf, fe, oe} !== 3'b000) begin
      n_fail++;
      $display("FAIL overrun_ack got %b required 000", {rdrf, fe, oe});
    end
    // Acknowledge in the stop-sample cycle of the second byte: completion
    // wins, so the new byte is accepted with no overrun. The stop sample is
    // on the 155th rising edge after the start-bit falling edge.
    send_frame(8'h11, 1'b1);
    sb_q.push_back({8'h22, 1'b0, 1'b0});
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        pulse_clr();
      end
    join
    exp_v = sb_q.pop_front();
    n_tests++;
    if ({rx_data, fe, oe, rdrf} !== {exp_v, 1'b1}) begin
      n_fail++;
      $display("FAIL overrun_clr got %h required %h", {rx_data, fe, oe, rdrf}, {exp_v, 1'b1});
    end
    pulse_clr();
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [4];
    bytes[0] = 8'hAA;
    bytes[1] = 8'h00;
    bytes[2] = 8'hFF;
    bytes[3] = 8'h81;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back({bytes[i], 1'b0, 1'b0});
      send_frame(bytes[i], 1'b1);
      exp_v = sb_q.pop_front();
      n_tests++;
      if ({rx_data, fe, oe, rdrf} !== {exp_v, 1'b1}) begin
        n_fail++;
        $display("FAIL loopback_%0d got %h required %h", i, {rx_data, fe, oe, rdrf}, {exp_v, 1'b1});
      end
      pulse_clr();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_nominal();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
